// File: rtl/syscall_unit.sv
// SYSCALL executor: decodes the service code, runs the console valid/ready handshake, stalls the PC until done.
// Optional handshake timeout is enabled by defining SYSCALL_TIMEOUT_EN.
module syscall_unit #(
  parameter int SYS_OP_W       = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                syscall,
  input  logic [SYS_OP_W-1:0] sys_op,
  input  logic [31:0]         arg,
  output logic                stall,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic                out_is_char,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  output logic                wb_en,
  output logic [31:0]         wb_data,
  output logic                exited,
  output logic                err
);

  localparam logic [SYS_OP_W-1:0] SYS_PRINT_INT  = SYS_OP_W'(1);
  localparam logic [SYS_OP_W-1:0] SYS_INPUT_INT  = SYS_OP_W'(5);
  localparam logic [SYS_OP_W-1:0] SYS_EXIT       = SYS_OP_W'(10);
  localparam logic [SYS_OP_W-1:0] SYS_PRINT_CHAR = SYS_OP_W'(11);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OUT_WAIT = 3'd1,
    IN_WAIT  = 3'd2,
    DONE     = 3'd3,
    HALTED   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] out_data_reg, out_data_next;
  logic        out_is_char_reg, out_is_char_next;
  logic [31:0] wb_data_reg, wb_data_next;
  logic        is_read_reg, is_read_next;
  logic        err_reg, err_next;

`ifdef SYSCALL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             timeout;

  assign timeout = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_next       = state_reg;
    out_data_next    = out_data_reg;
    out_is_char_next = out_is_char_reg;
    wb_data_next     = wb_data_reg;
    is_read_next     = is_read_reg;
    err_next         = err_reg;
`ifdef SYSCALL_TIMEOUT_EN
    count_next       = count_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (syscall) begin
          is_read_next = 1'b0;
`ifdef SYSCALL_TIMEOUT_EN
          count_next   = '0;
`endif
          if (sys_op == SYS_PRINT_INT || sys_op == SYS_PRINT_CHAR) begin
            out_data_next    = arg;
            out_is_char_next = (sys_op == SYS_PRINT_CHAR);
            state_next       = OUT_WAIT;
          end else if (sys_op == SYS_INPUT_INT) begin
            is_read_next = 1'b1;
            state_next   = IN_WAIT;
          end else if (sys_op == SYS_EXIT) begin
            state_next = HALTED;
          end else begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      OUT_WAIT: begin
        if (out_ready) begin
          state_next = DONE;
        end
`ifdef SYSCALL_TIMEOUT_EN
        else if (timeout) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          count_next = count_reg + 1'b1;
        end
`endif
      end
      IN_WAIT: begin
        if (in_valid) begin
          wb_data_next = in_data;
          state_next   = DONE;
        end
`ifdef SYSCALL_TIMEOUT_EN
        else if (timeout) begin
          // A timed-out read still commits, so $v0 gets a defined 0
          wb_data_next = '0;
          err_next     = 1'b1;
          state_next   = DONE;
        end else begin
          count_next = count_reg + 1'b1;
        end
`endif
      end
      DONE:    state_next = IDLE;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      out_data_reg    <= '0;
      out_is_char_reg <= 1'b0;
      wb_data_reg     <= '0;
      is_read_reg     <= 1'b0;
      err_reg         <= 1'b0;
`ifdef SYSCALL_TIMEOUT_EN
      count_reg       <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      out_data_reg    <= out_data_next;
      out_is_char_reg <= out_is_char_next;
      wb_data_reg     <= wb_data_next;
      is_read_reg     <= is_read_next;
      err_reg         <= err_next;
`ifdef SYSCALL_TIMEOUT_EN
      count_reg       <= count_next;
`endif
    end
  end

  // rst_n gates the IDLE stall path so reset drops stall even while syscall is held
  assign stall = rst_n && ((state_reg == IDLE) ? syscall
                         : (state_reg == OUT_WAIT || state_reg == IN_WAIT || state_reg == HALTED));
  assign out_valid   = (state_reg == OUT_WAIT);
  assign in_ready    = (state_reg == IN_WAIT);
  assign wb_en       = (state_reg == DONE) && is_read_reg;
  assign exited      = (state_reg == HALTED);
  assign out_data    = out_data_reg;
  assign out_is_char = out_is_char_reg;
  assign wb_data     = wb_data_reg;
  assign err         = err_reg;

endmodule
